// File: rtl/divider_unit.sv
// Sequential 32-bit signed restoring divider (MIPS DIV semantics): LO = quotient, HI = remainder.
// Optional macro DIV_ZERO_EXC_EN: flag a zero divisor at capture and finish in one cycle.
module divider_unit (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [31:0] RegAOut,
  input  logic signed [31:0] RegBOut,
  input  logic               DivCtrl,
  output logic               DivDone,
  output logic               DivZero,
  output logic        [5:0]  counter,
  output logic        [31:0] DivHIOut,
  output logic        [31:0] DivLOOut
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t              state;
  logic [DATA_W:0]     rem;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   mag_b;
  logic                sign_a;
  logic                sign_b;
  logic [DATA_W:0]     trial;
  logic [DATA_W:0]     diff;
  logic                fits;

  // |0x80000000| stays 0x80000000 because the result is read as unsigned
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
    magnitude = x[DATA_W-1] ? DATA_W'(-x) : DATA_W'(x);
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                   input logic neg);
    apply_sign = neg ? (~mag + DATA_W'(1)) : mag;
  endfunction

  // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  always_comb begin
    trial = {rem[DATA_W-1:0], quo[DATA_W-1]};
    diff  = trial - {1'b0, mag_b};
    fits  = (trial >= {1'b0, mag_b});
  end

`ifdef DIV_ZERO_EXC_EN
  logic div_zero_q;
  assign DivZero = div_zero_q;
`else
  assign DivZero = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      counter  <= '0;
      DivDone  <= 1'b0;
      DivHIOut <= '0;
      DivLOOut <= '0;
      rem      <= '0;
      quo      <= '0;
      mag_b    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (DivCtrl) begin
            quo     <= magnitude(RegAOut);
            mag_b   <= magnitude(RegBOut);
            sign_a  <= RegAOut[DATA_W-1];
            sign_b  <= RegBOut[DATA_W-1];
            rem     <= '0;
            counter <= '0;
            DivDone <= 1'b0;
            state   <= RUN;
`ifdef DIV_ZERO_EXC_EN
            div_zero_q <= 1'b0;
            if (RegBOut == '0) begin
              div_zero_q <= 1'b1;
              DivDone    <= 1'b1;
              state      <= DONE;
            end
`endif
          end
        end
        RUN: begin
          if (!DivCtrl) begin
            state <= IDLE;
          end else begin
            rem     <= fits ? diff : trial;
            quo     <= {quo[DATA_W-2:0], fits};
            counter <= counter + 6'd1;
            if (counter == 6'd31) state <= FIX;
          end
        end
        FIX: begin
          if (!DivCtrl) begin
            state <= IDLE;
          end else begin
            DivLOOut <= apply_sign(quo, sign_a ^ sign_b);
            DivHIOut <= apply_sign(rem[DATA_W-1:0], sign_a);
            DivDone  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (!DivCtrl) begin
            DivDone <= 1'b0;
`ifdef DIV_ZERO_EXC_EN
            div_zero_q <= 1'b0;
`endif
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit: signed cases, overflow, zero divisor, abort and async reset.
module tb_divider_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] RegAOut;
  logic [31:0] RegBOut;
  logic        DivCtrl;
  logic        DivDone;
  logic        DivZero;
  logic [5:0]  counter;
  logic [31:0] DivHIOut;
  logic [31:0] DivLOOut;

  int checks = 0;
  int errors = 0;

  divider_unit dut (
    .clock    (clock),
    .reset    (reset),
    .RegAOut  (RegAOut),
    .RegBOut  (RegBOut),
    .DivCtrl  (DivCtrl),
    .DivDone  (DivDone),
    .DivZero  (DivZero),
    .counter  (counter),
    .DivHIOut (DivHIOut),
    .DivLOOut (DivLOOut)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    RegAOut = a;
    RegBOut = b;
    DivCtrl = 1'b1;
  endtask

  // Full run: 33 edges leave DivDone low with counter at 32, edge 34 publishes.
  task automatic run_full(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] hi);
    start(a, b);
    tick(33);
    chk({tag, "_done_early"}, {31'd0, DivDone}, 32'd0);
    chk({tag, "_cnt"}, {26'd0, counter}, 32'd32);
    tick(1);
    chk({tag, "_done"}, {31'd0, DivDone}, 32'd1);
    chk({tag, "_lo"}, DivLOOut, lo);
    chk({tag, "_hi"}, DivHIOut, hi);
    chk({tag, "_zero"}, {31'd0, DivZero}, 32'd0);
    tick(2);
    chk({tag, "_hold"}, {31'd0, DivDone}, 32'd1);
    DivCtrl = 1'b0;
    tick(1);
    chk({tag, "_clr"}, {31'd0, DivDone}, 32'd0);
  endtask

  initial begin
    reset   = 1'b0;
    DivCtrl = 1'b0;
    RegAOut = '0;
    RegBOut = '0;
    tick(2);
    chk("rst_done", {31'd0, DivDone}, 32'd0);
    chk("rst_zero", {31'd0, DivZero}, 32'd0);
    chk("rst_cnt", {26'd0, counter}, 32'd0);
    chk("rst_hi", DivHIOut, 32'd0);
    chk("rst_lo", DivLOOut, 32'd0);
    reset = 1'b1;
    tick(1);

    run_full("d100_7", 32'd100, 32'd7, 32'h0000000E, 32'h00000002);
    run_full("dm7_2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_full("d7_m2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
    run_full("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);

`ifdef DIV_ZERO_EXC_EN
    start(32'd5, 32'd0);
    tick(1);
    chk("dz_done", {31'd0, DivDone}, 32'd1);
    chk("dz_flag", {31'd0, DivZero}, 32'd1);
    chk("dz_lo", DivLOOut, 32'h80000000);
    chk("dz_hi", DivHIOut, 32'h00000000);
    DivCtrl = 1'b0;
    tick(1);
    chk("dz_clr_done", {31'd0, DivDone}, 32'd0);
    chk("dz_clr_flag", {31'd0, DivZero}, 32'd0);
`else
    run_full("dz", 32'd5, 32'd0, 32'hFFFFFFFF, 32'h00000005);
    run_full("dz_neg", 32'hFFFFFFFB, 32'd0, 32'h00000001, 32'hFFFFFFFB);
`endif

    // Operands changing after capture must not disturb the result.
    start(32'd1000, 32'd9);
    tick(1);
    RegAOut = 32'hDEADBEEF;
    RegBOut = 32'd3;
    tick(33);
    chk("late_lo", DivLOOut, 32'd111);
    chk("late_hi", DivHIOut, 32'd1);
    DivCtrl = 1'b0;
    tick(1);

    // Abort mid-run: results from the 1000/9 run must survive.
    start(32'd100, 32'd7);
    tick(11);
    chk("abort_cnt", {26'd0, counter}, 32'd10);
    DivCtrl = 1'b0;
    tick(1);
    chk("abort_done", {31'd0, DivDone}, 32'd0);
    tick(40);
    chk("abort_done_late", {31'd0, DivDone}, 32'd0);
    chk("abort_lo", DivLOOut, 32'd111);
    chk("abort_hi", DivHIOut, 32'd1);
    run_full("d9_3", 32'd9, 32'd3, 32'd3, 32'd0);

    // Asynchronous reset in the middle of an iteration.
    start(32'hFFFFFF9C, 32'd7);
    tick(21);
    chk("pre_rst_cnt", {26'd0, counter}, 32'd20);
    #2 reset = 1'b0;
    #1;
    chk("arst_cnt", {26'd0, counter}, 32'd0);
    chk("arst_done", {31'd0, DivDone}, 32'd0);
    chk("arst_zero", {31'd0, DivZero}, 32'd0);
    chk("arst_lo", DivLOOut, 32'd0);
    chk("arst_hi", DivHIOut, 32'd0);
    tick(1);
    reset = 1'b1;
    run_full("post_rst", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
# divider_unit

Sequential 32-bit signed integer divider for the datapath's HI/LO unit, the inverse counterpart of the Booth multiplier. It takes dividend RegAOut and divisor RegBOut, iterates one quotient bit per clock using restoring division on magnitudes, and writes quotient to DivLOOut and remainder to DivHIOut with MIPS DIV semantics. The control unit drives DivCtrl high and waits for DivDone.

## Interface
- No parameters; width fixed at 32.
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low; clears all state and outputs.
- RegAOut  input  32  dividend, signed two's complement; sampled at start.
- RegBOut  input  32  divisor, signed two's complement; sampled at start.
- DivCtrl  input  1  level request; start and hold for the whole operation.
- DivDone  output  1  result valid; held while DivCtrl stays high in DONE.
- DivZero  output  1  divide-by-zero flag (see Configuration).
- counter  output  6  iterations completed, 0..32.
- DivHIOut  output  32  remainder.
- DivLOOut  output  32  quotient.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: on edge with DivCtrl=1, latch |RegAOut|, |RegBOut|, sign of each; clear counter, partial remainder, DivDone, DivZero; go RUN. With RegBOut=0 and DIV_ZERO_EXC_EN defined, go directly to DONE with DivZero=1, DivDone=1, HI/LO unchanged.
- RUN: R = {R[31:0], next dividend MSB}; if R >= |divisor| then R -= |divisor|, quotient bit 1, else 0; counter += 1. After counter reaches 32, go FIX.
- FIX: quotient negated if signs differ; remainder negated if dividend negative; write DivLOOut/DivHIOut; DivDone=1; go DONE.
- DONE: hold outputs. DivCtrl=0 → clear DivDone, DivZero; go IDLE. A new operation requires DivCtrl low for at least one edge.
- Partial remainder is 33 bits; magnitudes 32 bits unsigned (|0x80000000| = 0x80000000).
- Truncation toward zero; remainder carries dividend's sign.
- Overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no flag.
- DivCtrl falling in RUN or FIX: abort; go IDLE next edge; HI/LO keep previous results; DivDone stays 0.
- reset low at any time: state IDLE, counter=0, DivDone=0, DivZero=0, DivHIOut=0, DivLOOut=0, immediately (asynchronous).

## Timing
- Edge 1 (first edge with DivCtrl=1 in IDLE): capture.
- Edges 2..33: 32 iterations; counter reads 1..32.
- Edge 34: FIX writes outputs, DivDone=1; latency 34 cycles from request.
- Divide-by-zero with macro: DivDone=DivZero=1 after edge 1.
- HI/LO change only at FIX edge or reset; never mid-iteration.
- Operands may change after edge 1 without effect.

## Configuration
- DIV_ZERO_EXC_EN defined: zero divisor detected at capture; 1-cycle completion with DivZero=1, DivDone=1, HI/LO unchanged.
- Not defined: DivZero tied 0; zero divisor runs full 34-cycle algorithm, yielding magnitude quotient 0xFFFFFFFF (LO=0xFFFFFFFF for dividend >= 0, 0x00000001 for dividend < 0) and HI=dividend.

## Test plan
- 100 / 7, DivCtrl held → DivDone rises after edge 34; LO=0x0000000E, HI=0x00000002; counter=32.
- -7 / 2 (0xFFFFFFF9 / 2) → LO=0xFFFFFFFD, HI=0xFFFFFFFF; 7 / -2 → LO=0xFFFFFFFD, HI=0x00000001.
- 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0x00000000, DivZero=0.
- 5 / 0 with DIV_ZERO_EXC_EN → DivDone=DivZero=1 after edge 1, HI/LO keep prior values; without macro → after 34 edges LO=0xFFFFFFFF, HI=0x00000005, DivZero=0.
- Start 100/7, drop DivCtrl at counter=10 → IDLE next edge, DivDone never asserts, HI/LO unchanged; restart 9/3 → LO=3, HI=0.
- Assert reset low mid-RUN (counter=20) asynchronously → all outputs 0, counter=0 immediately; after release with DivCtrl high, fresh operation completes in 34 cycles.
